reg_file_sb: RTL

Parametrised two-read/one-write register file with same-cycle write forwarding, a hardwired zero register, an output hold for pipeline stalls, and a per-register pending-write scoreboard. It sits in the decode stage. It supplies registered source operands to execute, accepts writeback from the final stage, and flags read-after-write hazards against in-flight multi-cycle results. It is the next generation of the 16×16 register file, with full reset, forwarding and hazard tracking added.

---
 rtl/reg_file_sb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: decode-stage register file, two registered read ports, one
// write port, same-cycle write forwarding, hardwired zero register, read-output
// hold for stalls and a per-register pending-write scoreboard.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   rs1, rs2          read indices; reg1/reg2 valid one edge later
//   rd, writedata,
//   write             writeback port (drops writes to register 0)
//   hold              freezes reg1/reg2/hazard1/hazard2; writes still happen
//   reserve,
//   reserve_rd        marks a register as having an in-flight producer
//   reg1, reg2        registered read data
//   hazard1, hazard2  registered: read value is stale (pending producer)
//   busy              scoreboard vector, bit i = register i pending
module reg_file_sb #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_REG    = 16,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REG)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] writedata,
   input  logic                  write,
   input  logic                  hold,
   input  logic                  reserve,
   input  logic [ADDR_WIDTH-1:0] reserve_rd,
   output logic [DATA_WIDTH-1:0] reg1,
   output logic [DATA_WIDTH-1:0] reg2,
   output logic                  hazard1,
   output logic                  hazard2,
   output logic [NUM_REG-1:0]    busy
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REG];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REG];
   logic [NUM_REG-1:0]    busy_q, busy_d;
   logic [DATA_WIDTH-1:0] reg1_q, reg1_d;
   logic [DATA_WIDTH-1:0] reg2_q, reg2_d;
   logic                  hazard1_q, hazard1_d;
   logic                  hazard2_q, hazard2_d;

   logic wr_en_c;
   logic fwd1_c, fwd2_c;

   assign wr_en_c = write && (rd != '0);
   assign fwd1_c  = write && (rd == rs1);
   assign fwd2_c  = write && (rd == rs2);

   // Array update; register 0 is pinned to zero.
   always_comb begin
      regs_d = regs_q;
      if (wr_en_c) begin
         regs_d[rd] = writedata;
      end
      regs_d[0] = '0;
   end

   // Scoreboard: a new reservation beats a same-cycle writeback clear.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned i = 1; i < NUM_REG; i++) begin
         if (reserve && (reserve_rd == ADDR_WIDTH'(i))) begin
            busy_d[i] = 1'b1;
         end else if (write && (rd == ADDR_WIDTH'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Read ports: zero register, then forwarding, then array. Hazards use the
   // pre-edge scoreboard, so a same-cycle reserve never flags the older reader.
   always_comb begin
      reg1_d    = reg1_q;
      reg2_d    = reg2_q;
      hazard1_d = hazard1_q;
      hazard2_d = hazard2_q;
      if (!hold) begin
         if (rs1 == '0) begin
            reg1_d = '0;
         end else if (fwd1_c) begin
            reg1_d = writedata;
         end else begin
            reg1_d = regs_q[rs1];
         end
         if (rs2 == '0) begin
            reg2_d = '0;
         end else if (fwd2_c) begin
            reg2_d = writedata;
         end else begin
            reg2_d = regs_q[rs2];
         end
         hazard1_d = (rs1 != '0) && busy_q[rs1] && !fwd1_c;
         hazard2_d = (rs2 != '0) && busy_q[rs2] && !fwd2_c;
      end
   end

   // State registers; reset overrides write, reserve and hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q    <= '0;
         reg1_q    <= '0;
         reg2_q    <= '0;
         hazard1_q <= 1'b0;
         hazard2_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_REG; i++) begin
            regs_q[i] <= regs_d[i];
         end
         busy_q    <= busy_d;
         reg1_q    <= reg1_d;
         reg2_q    <= reg2_d;
         hazard1_q <= hazard1_d;
         hazard2_q <= hazard2_d;
      end
   end

   assign reg1    = reg1_q;
   assign reg2    = reg2_q;
   assign hazard1 = hazard1_q;
   assign hazard2 = hazard2_q;
   assign busy    = busy_q;

endmodule
